psram_request_arbiter: RTL and testbench

//  Shares one QSPI PSRAM controller port among NUM_REQ requesters (CPU, DMA, video fetch).

---
 rtl/psram_arb_pkg.sv | 54 +++++
 rtl/psram_rr_picker.sv | 29 ++
 rtl/psram_request_arbiter.sv | 159 +++++++++++++++
 tb/tb_psram_request_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arb_pkg.sv
// Shared types and helpers for the PSRAM request arbiter.
//
// Contents
//   arb_state_t             arbiter FSM state encoding
//   DEFAULT_TIMEOUT_CYCLES  default watchdog limit in cycles (mem_req rise to mem_ack rise)
//   MAX_REQ                 largest supported requester count
//   rr_pick()               round-robin search for the first set request after a pointer

package psram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_REL,
        RESP
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned MAX_REQ                = 8;

    // Returns the index of the first set bit in req[num_req-1:0], searching
    // from rr+1 upward and wrapping. Returns 0 when nothing is set.
    // The caller must keep rr < num_req.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         rr,
        input int unsigned        num_req
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        // NOTE: every local gets a value before the loop, so no path leaves
        // one holding an old value and combinational users infer no latch.
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            if (i <= num_req) begin
                // rr < num_req and i <= num_req, so a single subtraction wraps.
                idx = 32'(rr) + i;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (!found && req[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/psram_rr_picker.sv
// Combinational round-robin picker.
//
// Ports
//   req    in  NUM_REQ  request vector to search
//   rr     in  ID_W     pointer to the most recently served requester
//   idx    out ID_W     first set request after rr (wrapping)
//   valid  out 1        at least one request is set

module psram_rr_picker
    import psram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         pick;

    assign req_ext = MAX_REQ'(req);
    assign pick    = rr_pick(req_ext, 3'(rr), NUM_REQ);
    assign idx     = ID_W'(pick);
    assign valid   = |req;

endmodule

// File: rtl/psram_request_arbiter.sv
// Shares one QSPI PSRAM controller port among NUM_REQ requesters with
// round-robin arbitration and 4-phase req/ack handshakes on both sides.
// A watchdog aborts a grant whose memory ack does not arrive within
// TIMEOUT_CYCLES and reports it through req_err.
//
// Build option
//   PSRAM_ARB_PRIORITY_EN  requester 0 always wins in IDLE; the rest rotate
//                          among themselves and requester 0 never moves rr.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   req/req_nwr       per-requester request level and direction (1 = write)
//   req_address       packed addresses, requester i at [i*ADDRESS_SIZE +: ADDRESS_SIZE]
//   req_data_in       packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_data_out      shared read data, held until the next read completes
//   req_ack/req_err   per-requester ack level and timeout flag
//   mem_*             request/ack port toward the PSRAM controller
//   grant_id          current or last granted requester
//   busy              FSM is outside IDLE

module psram_request_arbiter
    import psram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDRESS_SIZE   = 24,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_nwr,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
    output logic [DATA_WIDTH-1:0]          req_data_out,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_err,
    output logic                           mem_req,
    output logic                           mem_nwr,
    output logic [ADDRESS_SIZE-1:0]        mem_address,
    output logic [DATA_WIDTH-1:0]          mem_data_out,
    input  logic [DATA_WIDTH-1:0]          mem_data_in,
    input  logic                           mem_ack,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int unsigned ID_W         = $clog2(NUM_REQ);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t          state;
    logic [ID_W-1:0]     rr;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     next_id;
    logic                pick_valid;
    logic                any_req;
    logic [NUM_REQ-1:0]  pick_req;
    logic                err;
    logic [15:0]         counter;

`ifdef PSRAM_ARB_PRIORITY_EN
    // Requester 0 is taken out of the rotation and overrides it.
    assign pick_req = req & ~NUM_REQ'(1);
    assign next_id  = req[0] ? '0 : pick_id;
    assign any_req  = req[0] | pick_valid;
`else
    assign pick_req = req;
    assign next_id  = pick_id;
    assign any_req  = pick_valid;
`endif

    psram_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (pick_req),
        .rr    (rr),
        .idx   (pick_id),
        .valid (pick_valid)
    );

    assign busy = (state != IDLE);

    // NOTE: sequential state is written with <= only, so every register in
    // this block samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr           <= '0;
            counter      <= '0;
            err          <= 1'b0;
            grant_id     <= '0;
            mem_req      <= 1'b0;
            mem_nwr      <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
            req_data_out <= '0;
            req_ack      <= '0;
            req_err      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // The mem_* registers double as the latch for the granted request.
                    if (any_req) begin
                        grant_id     <= next_id;
                        mem_nwr      <= req_nwr[next_id];
                        mem_address  <= req_address[32'(next_id)*ADDRESS_SIZE +: ADDRESS_SIZE];
                        mem_data_out <= req_data_in[32'(next_id)*DATA_WIDTH +: DATA_WIDTH];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req <= 1'b1;
                    counter <= '0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (mem_ack) begin
                        if (!mem_nwr) begin
                            req_data_out <= mem_data_in;
                        end
                        mem_req <= 1'b0;
                        state   <= WAIT_REL;
                    end else if (counter == TIMEOUT_LAST) begin
                        // Abort; a late ack is absorbed by waiting for it to fall.
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= WAIT_REL;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                WAIT_REL: begin
                    if (!mem_ack) begin
                        req_ack[grant_id] <= 1'b1;
                        req_err[grant_id] <= err;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    if (!req[grant_id]) begin
                        req_ack <= '0;
                        req_err <= '0;
                        err     <= 1'b0;
`ifdef PSRAM_ARB_PRIORITY_EN
                        if (grant_id != '0) begin
                            rr <= grant_id;
                        end
`else
                        rr <= grant_id;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_request_arbiter.sv
// Self-checking bench for psram_request_arbiter.
// Expected grants are queued as stimulus is issued; a memory responder pops
// and compares them as mem_req rises. Requesters compare their own responses.
// Build with PSRAM_ARB_PRIORITY_EN to exercise the fixed-priority variant.

module tb_psram_request_arbiter;

`ifdef PSRAM_ARB_PRIORITY_EN
    localparam int unsigned NUM_REQ = 3;
`else
    localparam int unsigned NUM_REQ = 2;
`endif
    localparam int unsigned AS   = 24;
    localparam int unsigned DW   = 32;
    localparam int unsigned TMO  = 16;
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_nwr;
    logic [NUM_REQ*AS-1:0]  req_address;
    logic [NUM_REQ*DW-1:0]  req_data_in;
    logic [DW-1:0]          req_data_out;
    logic [NUM_REQ-1:0]     req_ack;
    logic [NUM_REQ-1:0]     req_err;
    logic                   mem_req;
    logic                   mem_nwr;
    logic [AS-1:0]          mem_address;
    logic [DW-1:0]          mem_data_out;
    logic [DW-1:0]          mem_data_in;
    logic                   mem_ack;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;

    typedef struct {
        int unsigned id;
        logic        nwr;
        logic [AS-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic        silent;
        int unsigned hold;
        int unsigned delay;
    } grant_t;

    grant_t      grant_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    psram_request_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDRESS_SIZE   (AS),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_nwr      (req_nwr),
        .req_address  (req_address),
        .req_data_in  (req_data_in),
        .req_data_out (req_data_out),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .mem_req      (mem_req),
        .mem_nwr      (mem_nwr),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_ack      (mem_ack),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [AS-1:0] a);
        return {8'h5A, a} ^ 32'h0F0F_0F0F;
    endfunction

    function automatic logic [AS-1:0] addr_of(input int unsigned i, input int unsigned k);
        return AS'(32'h0010_0000 + i * 16 + k);
    endfunction

    function automatic void push_grant(input int unsigned id, input logic nwr,
                                       input logic [AS-1:0] addr, input logic [DW-1:0] wdata,
                                       input logic [DW-1:0] rdata, input logic silent,
                                       input int unsigned hold, input int unsigned delay);
        grant_t g;
        g.id = id; g.nwr = nwr; g.addr = addr; g.wdata = wdata;
        g.rdata = rdata; g.silent = silent; g.hold = hold; g.delay = delay;
        grant_q.push_back(g);
    endfunction

    // Memory-side responder: checks each grant against the queue, then
    // either acks after g.delay cycles or stays silent and measures how long
    // mem_req is held.
    initial begin
        grant_t      g;
        int unsigned cnt;
        mem_ack     = 1'b0;
        mem_data_in = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_ack === 1'b0) begin
                if (grant_q.size() == 0) begin
                    check("pending_grants", 32'(grant_q.size()), 32'd1);
                    for (int k = 0; k < 1000; k++) begin
                        @(negedge clk);
                        if (mem_req !== 1'b1) break;
                    end
                end else begin
                    g = grant_q.pop_front();
                    check("grant_id", 32'(grant_id), 32'(g.id));
                    check("mem_nwr", 32'(mem_nwr), 32'(g.nwr));
                    check("mem_address", 32'(mem_address), 32'(g.addr));
                    if (g.nwr) check("mem_data_out", mem_data_out, g.wdata);
                    if (g.silent) begin
                        cnt = 1;
                        for (int k = 0; k < 1000; k++) begin
                            @(negedge clk);
                            if (mem_req !== 1'b1) break;
                            cnt++;
                        end
                        if (g.hold != 0) check("mem_req_hold", 32'(cnt), 32'(g.hold));
                    end else begin
                        repeat (g.delay) @(negedge clk);
                        mem_data_in = g.rdata;
                        mem_ack     = 1'b1;
                        for (int k = 0; k < 50; k++) begin
                            @(negedge clk);
                            if (mem_req !== 1'b1) break;
                        end
                        check("mem_req_drop", 32'(mem_req), 32'd0);
                        mem_ack     = 1'b0;
                        mem_data_in = ~g.rdata;
                        @(negedge clk);
                        check("ack_latency", 32'(req_ack[g.id]), 32'd1);
                    end
                end
            end
        end
    end

    // One full requester-side handshake; called on a negedge.
    task automatic requester(input int unsigned i, input logic nwr, input logic [AS-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                             input logic exp_err, input bit chk_lat);
        int unsigned cyc = 0;
        int unsigned lat = 0;
        req_nwr[i]              = nwr;
        req_address[i*AS +: AS] = addr;
        req_data_in[i*DW +: DW] = wdata;
        req[i]                  = 1'b1;
        while (req_ack[i] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (chk_lat && lat == 0 && mem_req === 1'b1) lat = cyc;
        end
        check("req_ack", 32'(req_ack[i]), 32'd1);
        if (chk_lat) check("req_to_mem_req", 32'(lat), 32'd2);
        check("req_data_out", req_data_out, exp_rd);
        check("req_err", 32'(req_err[i]), 32'(exp_err));
        req[i] = 1'b0;
        cyc = 0;
        while (req_ack[i] !== 1'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ack_clear", 32'(req_ack[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int unsigned cyc;
        reset       = 1'b1;
        req         = '0;
        req_nwr     = '0;
        req_address = '0;
        req_data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_req_data_out", req_data_out, 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read, ack after 5 cycles.
        push_grant(0, 1'b0, 24'h000123, '0, 32'hDEAD_BEEF, 1'b0, 0, 5);
        requester(0, 1'b0, 24'h000123, '0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        last_rd = 32'hDEAD_BEEF;
        @(negedge clk);

`ifdef PSRAM_ARB_PRIORITY_EN
        // Requester 0 dominates while held; then 1 and 2 rotate.
        for (int k = 0; k < 3; k++) push_grant(0, 1'b0, addr_of(0, k), '0, data_of(addr_of(0, k)), 1'b0, 0, 2);
        push_grant(1, 1'b0, addr_of(1, 0), '0, data_of(addr_of(1, 0)), 1'b0, 0, 2);
        push_grant(2, 1'b0, addr_of(2, 0), '0, data_of(addr_of(2, 0)), 1'b0, 0, 2);
        push_grant(1, 1'b0, addr_of(1, 1), '0, data_of(addr_of(1, 1)), 1'b0, 0, 2);
        fork
            begin
                for (int k = 0; k < 3; k++)
                    requester(0, 1'b0, addr_of(0, k), '0, data_of(addr_of(0, k)), 1'b0, 1'b0);
            end
            begin
                requester(1, 1'b0, addr_of(1, 0), '0, data_of(addr_of(1, 0)), 1'b0, 1'b0);
                requester(1, 1'b0, addr_of(1, 1), '0, data_of(addr_of(1, 1)), 1'b0, 1'b0);
            end
            requester(2, 1'b0, addr_of(2, 0), '0, data_of(addr_of(2, 0)), 1'b0, 1'b0);
        join
        last_rd = data_of(addr_of(1, 1));
`else
        // Both held: rr=0 so order is 1,0,1,0.
        for (int k = 0; k < 2; k++) begin
            push_grant(1, 1'b0, addr_of(1, k), '0, data_of(addr_of(1, k)), 1'b0, 0, 2);
            push_grant(0, 1'b0, addr_of(0, k), '0, data_of(addr_of(0, k)), 1'b0, 0, 2);
        end
        fork
            begin
                for (int k = 0; k < 2; k++)
                    requester(0, 1'b0, addr_of(0, k), '0, data_of(addr_of(0, k)), 1'b0, 1'b0);
            end
            begin
                for (int k = 0; k < 2; k++)
                    requester(1, 1'b0, addr_of(1, k), '0, data_of(addr_of(1, k)), 1'b0, 1'b0);
            end
        join
        last_rd = data_of(addr_of(0, 1));
`endif
        @(negedge clk);

        // Write: read data must stay at the last read value.
        push_grant(1, 1'b1, 24'h00ABCD, 32'h1234_5678, 32'hBAD0_BAD0, 1'b0, 0, 3);
        requester(1, 1'b1, 24'h00ABCD, 32'h1234_5678, last_rd, 1'b0, 1'b0);
        @(negedge clk);

        // Timeout: no ack; mem_req held TMO cycles, err set, old data returned.
        push_grant(0, 1'b0, 24'h000777, '0, '0, 1'b1, TMO, 0);
        requester(0, 1'b0, 24'h000777, '0, last_rd, 1'b1, 1'b0);
        @(negedge clk);

        // Reset while waiting for the memory ack.
        push_grant(0, 1'b0, 24'h000999, '0, '0, 1'b1, 0, 0);
        req_nwr[0]        = 1'b0;
        req_address[0 +: AS] = 24'h000999;
        req[0]            = 1'b1;
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req_ack", 32'(req_ack), 32'd0);
        check("mid_rst_req_data_out", req_data_out, 32'd0);
        req[0] = 1'b0;
        reset  = 1'b0;
        @(negedge clk);

        // Normal read after reset, minimum ack delay.
        push_grant(1, 1'b0, 24'h0F00F0, '0, 32'hCAFE_F00D, 1'b0, 0, 1);
        requester(1, 1'b0, 24'h0F00F0, '0, 32'hCAFE_F00D, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("grants_left", 32'(grant_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
